// File: rtl/reg_issue_scoreboard_pkg.sv
// Shared constants for the WISC register issue scoreboard.
package reg_issue_scoreboard_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_ID_W = 4;
  localparam int CNT_MAX  = 3;
  localparam logic [REG_ID_W-1:0] ZERO_REG = 4'd0;

endpackage

// File: rtl/reg_issue_scoreboard_pending_counter.sv
// One per-register pending-write counter: counts up on issue, down on
// writeback, saturating at both ends, with a flush clear that dominates.
module pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins; simultaneous inc and dec cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/reg_issue_scoreboard.sv
// Decode-to-register-read issue stage: RAW/overflow hazard detection against
// a per-register pending-write scoreboard, plus the registered IDs that feed
// the register file's read and write decoders.
module reg_issue_scoreboard #(
  parameter int NUM_REGS = reg_issue_scoreboard_pkg::NUM_REGS,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [3:0]          iss_rs,
  input  logic [3:0]          iss_rt,
  input  logic                iss_rs_used,
  input  logic                iss_rt_used,
  input  logic [3:0]          iss_rd,
  input  logic                iss_rd_wr,
  input  logic                wb_valid,
  input  logic [3:0]          wb_reg,
  input  logic                flush,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [3:0]          rd_src1,
  output logic [3:0]          rd_src2,
  output logic [3:0]          rd_dst,
  output logic                rd_dst_wr,
  output logic [NUM_REGS-1:0] busy,
  output logic                sb_err
);

  import reg_issue_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CNT_MAX);

  logic [CNT_W-1:0]    cnt_w [NUM_REGS];
  logic [NUM_REGS-1:0] nz_w;
  logic [NUM_REGS-1:0] inc_w;
  logic [NUM_REGS-1:0] dec_w;
  logic [NUM_REGS-1:0] eff_nz_w;

  logic hazard;
  logic accept;

  logic       rd_valid_q, rd_valid_d;
  logic [3:0] rd_src1_q, rd_src1_d;
  logic [3:0] rd_src2_q, rd_src2_d;
  logic [3:0] rd_dst_q, rd_dst_d;
  logic       rd_dst_wr_q, rd_dst_wr_d;
  logic       sb_err_q, sb_err_d;

  // Scoreboard: R0 is hard-wired empty, R1..R15 each get a counter.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic wb_hit;
      assign wb_hit = wb_valid && (wb_reg == REG_ID_W'(gi));
      if (gi == 0) begin : g_zero
        assign cnt_w[gi]    = '0;
        assign nz_w[gi]     = 1'b0;
        assign inc_w[gi]    = 1'b0;
        assign dec_w[gi]    = 1'b0;
        assign eff_nz_w[gi] = 1'b0;
      end else begin : g_cnt
        assign inc_w[gi] = accept && iss_rd_wr && (iss_rd == REG_ID_W'(gi));
        // A writeback to an empty register is an error, not a decrement.
        assign dec_w[gi] = !flush && wb_hit && nz_w[gi];
        // Same-cycle writeback is visible to issue (register file bypasses).
        assign eff_nz_w[gi] = nz_w[gi] && !(wb_hit && (cnt_w[gi] == CNT_W'(1)));

        pending_counter #(.CNT_W(CNT_W)) u_cnt (
          .clk     (clk),
          .rst_n   (rst_n),
          .inc     (inc_w[gi]),
          .dec     (dec_w[gi]),
          .clr     (flush),
          .cnt     (cnt_w[gi]),
          .nonzero (nz_w[gi])
        );
      end
    end
  endgenerate

  // Hazard and handshake; deliberately independent of iss_valid.
  always_comb begin
    hazard = 1'b0;
    if (iss_rs_used && eff_nz_w[iss_rs]) hazard = 1'b1;
    if (iss_rt_used && eff_nz_w[iss_rt]) hazard = 1'b1;
    if (iss_rd_wr && (iss_rd != ZERO_REG) && (cnt_w[iss_rd] == CNT_FULL)) hazard = 1'b1;
    iss_ready = !flush && !hazard && (!rd_valid_q || rd_ready);
    accept    = iss_valid && iss_ready;
  end

  // Output pipeline register and sticky error next-state.
  always_comb begin
    rd_valid_d  = rd_valid_q;
    rd_src1_d   = rd_src1_q;
    rd_src2_d   = rd_src2_q;
    rd_dst_d    = rd_dst_q;
    rd_dst_wr_d = rd_dst_wr_q;
    sb_err_d    = sb_err_q;
    if (flush) begin
      rd_valid_d = 1'b0;
    end else begin
      if (accept) begin
        rd_valid_d  = 1'b1;
        rd_src1_d   = iss_rs_used ? iss_rs : ZERO_REG;
        rd_src2_d   = iss_rt_used ? iss_rt : ZERO_REG;
        rd_dst_d    = iss_rd;
        rd_dst_wr_d = iss_rd_wr;
      end else if (rd_ready) begin
        rd_valid_d = 1'b0;
      end
      if (wb_valid && (wb_reg != ZERO_REG) && !nz_w[wb_reg]) begin
        sb_err_d = 1'b1;
      end
    end
  end

  // Output and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q  <= 1'b0;
      rd_src1_q   <= '0;
      rd_src2_q   <= '0;
      rd_dst_q    <= '0;
      rd_dst_wr_q <= 1'b0;
      sb_err_q    <= 1'b0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_src1_q   <= rd_src1_d;
      rd_src2_q   <= rd_src2_d;
      rd_dst_q    <= rd_dst_d;
      rd_dst_wr_q <= rd_dst_wr_d;
      sb_err_q    <= sb_err_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_src1   = rd_src1_q;
  assign rd_src2   = rd_src2_q;
  assign rd_dst    = rd_dst_q;
  assign rd_dst_wr = rd_dst_wr_q;
  assign busy      = nz_w;
  assign sb_err    = sb_err_q;

endmodule

// File: tb/tb_reg_issue_scoreboard.sv
// Bench for reg_issue_scoreboard: directed scenarios followed by random
// traffic, all compared against a pending-count model kept as plain integers.
module tb_reg_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_ready;
  logic [3:0]  iss_rs, iss_rt, iss_rd;
  logic        iss_rs_used, iss_rt_used, iss_rd_wr;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        flush;
  logic        rd_valid, rd_ready;
  logic [3:0]  rd_src1, rd_src2, rd_dst;
  logic        rd_dst_wr;
  logic [15:0] busy;
  logic        sb_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int   m_cnt [16];
  bit   m_rv;
  int   m_s1, m_s2, m_d;
  bit   m_dw;
  bit   m_err;

  always #5 clk = ~clk;

  reg_issue_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_rs      (iss_rs),
    .iss_rt      (iss_rt),
    .iss_rs_used (iss_rs_used),
    .iss_rt_used (iss_rt_used),
    .iss_rd      (iss_rd),
    .iss_rd_wr   (iss_rd_wr),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .flush       (flush),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_src1     (rd_src1),
    .rd_src2     (rd_src2),
    .rd_dst      (rd_dst),
    .rd_dst_wr   (rd_dst_wr),
    .busy        (busy),
    .sb_err      (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_rv = 0; m_s1 = 0; m_s2 = 0; m_d = 0; m_dw = 0; m_err = 0;
  endfunction

  // Pending writes to r as seen by an issue this cycle (writeback counted).
  function automatic int eff_cnt(input int r);
    int c;
    if (r == 0) return 0;
    c = m_cnt[r];
    if (wb_valid && int'(wb_reg) == r && c != 0) c = c - 1;
    return c;
  endfunction

  function automatic bit model_ready();
    bit haz;
    haz = (iss_rs_used && eff_cnt(int'(iss_rs)) != 0) ||
          (iss_rt_used && eff_cnt(int'(iss_rt)) != 0) ||
          (iss_rd_wr && iss_rd != 0 && m_cnt[iss_rd] == 3);
    return !flush && !haz && (!m_rv || rd_ready);
  endfunction

  function automatic logic [15:0] model_busy();
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_rv));
    check({tag, ".rd_src1"},  32'(rd_src1),  32'(m_s1));
    check({tag, ".rd_src2"},  32'(rd_src2),  32'(m_s2));
    check({tag, ".rd_dst"},   32'(rd_dst),   32'(m_d));
    check({tag, ".rd_dst_wr"},32'(rd_dst_wr),32'(m_dw));
    check({tag, ".busy"},     32'(busy),     32'(model_busy()));
    check({tag, ".sb_err"},   32'(sb_err),   32'(m_err));
  endtask

  task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input int rd, input bit rdw, input bit wv, input int wr,
                        input bit fl, input bit rr);
    iss_valid = v; iss_rs = 4'(rs); iss_rs_used = rsu; iss_rt = 4'(rt); iss_rt_used = rtu;
    iss_rd = 4'(rd); iss_rd_wr = rdw; wb_valid = wv; wb_reg = 4'(wr); flush = fl; rd_ready = rr;
  endtask

  // One clock with the currently driven inputs; inputs are set just after an edge.
  task automatic step(input string tag);
    bit rdy, acc;
    int wr;
    #1;
    rdy = model_ready();
    check({tag, ".iss_ready"}, 32'(iss_ready), 32'(rdy));
    acc = iss_valid && rdy;
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_rv = 0;
    end else begin
      wr = int'(wb_reg);
      if (wb_valid && wr != 0) begin
        if (m_cnt[wr] == 0) m_err = 1;
        else m_cnt[wr] = m_cnt[wr] - 1;
      end
      if (acc && iss_rd_wr && iss_rd != 0) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
      if (acc) begin
        m_rv = 1;
        m_s1 = iss_rs_used ? int'(iss_rs) : 0;
        m_s2 = iss_rt_used ? int'(iss_rt) : 0;
        m_d  = int'(iss_rd);
        m_dw = iss_rd_wr;
      end else if (rd_ready) begin
        m_rv = 0;
      end
    end
    if (acc)
      $display("%s: issue rs=%0d rt=%0d rd=%0d wr=%0b wb=%0b/%0d busy=%04h",
               tag, m_s1, m_s2, m_d, m_dw, wb_valid, wb_reg, model_busy());
    #1;
    check_outputs(tag);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First issue, then its effect on the registered outputs.
    set_in(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 1);
    step("tp1");
    check("tp1.busy_const", 32'(busy), 32'h0008);

    // RAW on R3 stalls, then clears through a same-cycle writeback.
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("raw_stall");
    set_in(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 1);
    step("raw_wb");
    check("raw_wb.busy3", 32'(busy[3]), 32'd0);

    // Overflow on R5.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
      step("r5_fill");
    end
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1);
    step("r5_full");
    set_in(1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 1);
    step("r5_wb");
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1);
      step("r5_drain");
    end

    // Downstream backpressure, then release with a back-to-back load.
    set_in(1, 1, 1, 2, 0, 6, 1, 0, 0, 0, 1);
    step("bp_load");
    set_in(1, 2, 1, 1, 1, 8, 1, 0, 0, 0, 0);
    step("bp_hold");
    set_in(1, 2, 1, 1, 1, 8, 1, 0, 0, 0, 1);
    step("bp_release");

    // Flush with pending R4 and R7.
    set_in(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1);
    step("fl_w4");
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1);
    step("fl_w7");
    set_in(1, 1, 1, 0, 0, 9, 1, 1, 4, 1, 1);
    step("flush");
    check("flush.busy_const", 32'(busy), 32'h0000);

    // Writeback to an empty register is sticky; R0 never stalls or counts.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1);
    step("sb_err");
    check("sb_err.const", 32'(sb_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_in(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1);
      step("r0");
    end

    // Random traffic with an asynchronous reset dropped in mid-run.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      set_in($urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
